// File: rtl/divider_n_bits_buffer.sv
`default_nettype none
// ============================================================================
// Module  : divider_n_bits_buffer
// Brief   : Buffered restoring divider, 2N/N -> 2N quotient, N remainder.
// Revision: 1.0 - initial release
// ============================================================================
module divider_n_bits_buffer #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   data_in,
    input  logic           load,
    input  logic [1:0]     sel,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2*N + 1);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_RUN   = 1'b1;
    localparam logic [CW-1:0] C_ITERS = CW'(2*N);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [0:0]     r_state;
    logic [2*N-1:0] r_a;
    logic [N-1:0]   r_b;
    logic [2*N-1:0] r_q;
    logic [N-1:0]   r_r;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_quotient;
    logic [N-1:0]   r_remainder;
    logic           r_done;
    logic           r_dbz;

    logic [N:0]     w_s;
    logic           w_ge;
    logic [N-1:0]   w_diff;
    logic [N-1:0]   w_r_next;
    logic [2*N-1:0] w_q_next;

    // Partial remainder always stays below B, so its top bit is never needed;
    // the N-bit difference is exact whenever S >= B.
    always_comb begin
        w_s      = {r_r, r_q[2*N-1]};
        w_ge     = (w_s >= {1'b0, r_b});
        w_diff   = w_s[N-1:0] - r_b;
        w_r_next = w_ge ? w_diff : w_s[N-1:0];
        w_q_next = {r_q[2*N-2:0], w_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        case (sel)
                            2'b00: begin
                                r_a[N-1:0] <= data_in;
                                r_done     <= 1'b0;
                            end
                            2'b01: begin
                                r_a[2*N-1:N] <= data_in;
                                r_done       <= 1'b0;
                            end
                            2'b10: begin
                                r_b    <= data_in;
                                r_done <= 1'b0;
                            end
                            default: begin
                                if (r_b == '0) begin
                                    r_quotient  <= '1;
                                    r_remainder <= r_a[N-1:0];
                                    r_dbz       <= 1'b1;
                                    r_done      <= 1'b1;
                                end else begin
                                    r_q     <= r_a;
                                    r_r     <= '0;
                                    r_cnt   <= C_ITERS;
                                    r_done  <= 1'b0;
                                    r_dbz   <= 1'b0;
                                    r_state <= S_RUN;
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign busy        = (r_state == S_RUN);
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider_n_bits_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider_n_bits_buffer
// Brief   : Self-checking bench for divider_n_bits_buffer against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_divider_n_bits_buffer;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   data_in;
    logic           load;
    logic [1:0]     sel;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;

    int n_checks;
    int n_pass;

    // Model: operand buffers and last completed result
    logic [2*N-1:0] m_a;
    logic [N-1:0]   m_b;
    logic [2*N-1:0] m_q;
    logic [N-1:0]   m_r;

    divider_n_bits_buffer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load        (load),
        .sel         (sel),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    // One-edge command; returns at the negedge following the sampling edge.
    task automatic cmd(input logic [1:0] s, input logic [N-1:0] d);
        @(negedge clk);
        load    = 1'b1;
        sel     = s;
        data_in = d;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic load_a(input logic [2*N-1:0] a);
        cmd(2'b00, a[N-1:0]);
        cmd(2'b01, a[2*N-1:N]);
        m_a = a;
    endtask

    task automatic load_b(input logic [N-1:0] b);
        cmd(2'b10, b);
        m_b = b;
    endtask

    // Start a division and check it against plain arithmetic. With inject set,
    // a divisor load and a second start are attempted mid-run.
    task automatic start_check(input string tag, input bit inject);
        int cycles;
        bit held;
        logic [2*N-1:0] prev_q;
        logic [N-1:0]   prev_r;
        prev_q = m_q;
        prev_r = m_r;
        cmd(2'b11, '0);
        if (m_b == '0) begin
            m_q = '1;
            m_r = m_a[N-1:0];
            check({tag, " dbz"},  32'(div_by_zero), 32'd1);
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " busy"}, 32'(busy), 32'd0);
            check({tag, " q"},    32'(quotient), 32'(m_q));
            check({tag, " r"},    32'(remainder), 32'(m_r));
        end else begin
            m_q = m_a / {8'd0, m_b};
            m_r = N'(m_a % {8'd0, m_b});
            check({tag, " busy@0"}, 32'(busy), 32'd1);
            check({tag, " done@0"}, 32'(done), 32'd0);
            cycles = 0;
            held   = (quotient === prev_q) && (remainder === prev_r);
            while (done !== 1'b1 && cycles < 40) begin
                if (inject && cycles == 4) begin
                    load = 1'b1; sel = 2'b10; data_in = 8'h02;
                end else if (inject && cycles == 5) begin
                    sel = 2'b11;
                end else begin
                    load = 1'b0;
                end
                @(negedge clk);
                cycles++;
                if (done !== 1'b1) begin
                    if (quotient !== prev_q || remainder !== prev_r) held = 1'b0;
                    if (busy !== 1'b1) held = 1'b0;
                end
            end
            load = 1'b0;
            check({tag, " latency"}, 32'(cycles), 32'd16);
            check({tag, " held"},    32'(held), 32'd1);
            check({tag, " q"},       32'(quotient), 32'(m_q));
            check({tag, " r"},       32'(remainder), 32'(m_r));
            check({tag, " dbz"},     32'(div_by_zero), 32'd0);
            check({tag, " busy"},    32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        load     = 1'b0;
        sel      = 2'b00;
        data_in  = '0;
        m_a = '0; m_b = '0; m_q = '0; m_r = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst q",    32'(quotient), 32'd0);
        check("rst r",    32'(remainder), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst dbz",  32'(div_by_zero), 32'd0);
        rst = 1'b0;

        load_a(16'h00C8); load_b(8'h07);
        start_check("c8/7", 1'b0);
        check("c8/7 done", 32'(done), 32'd1);
        load_a(16'h00C8);
        check("load clears done", 32'(done), 32'd0);

        load_a(16'hFFFF); load_b(8'h01);
        start_check("ffff/1", 1'b0);
        load_b(8'hFF);
        start_check("ffff/ff", 1'b0);
        load_a(16'h0005); load_b(8'h09);
        start_check("5/9", 1'b0);
        load_a(16'hFFFE); load_b(8'hFF);
        start_check("fffe/ff", 1'b0);
        load_a(16'h1234); load_b(8'h00);
        start_check("1234/0", 1'b0);

        // Commands while busy must be ignored; B must still be 7 afterwards
        load_a(16'h00C8); load_b(8'h07);
        start_check("inject", 1'b1);
        start_check("reuse", 1'b0);

        // Asynchronous reset mid-run, asserted between clock edges
        cmd(2'b11, '0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst q",    32'(quotient), 32'd0);
        check("arst r",    32'(remainder), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst dbz",  32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_a = '0; m_b = '0; m_q = '0; m_r = '0;
        start_check("post-rst 0/0", 1'b0);

        for (int i = 0; i < 24; i++) begin
            int unsigned pick;
            pick = $urandom_range(0, 9);
            if (pick > 1) begin
                if (pick < 4) load_a(16'($urandom_range(0, 255)));
                else          load_a(16'($urandom));
                if (pick == 9) load_b(8'h00);
                else           load_b(8'($urandom));
            end
            start_check($sformatf("rnd%0d", i), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
